// File: rtl/seg7_pkg.sv
// Shared constants, glyph codes and capture-FSM state type for the 7-segment scan decoder.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned HEX_W      = 4;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W      = 8;

  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h7E;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h30;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h33;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h5F;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h70;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h7B;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h1F;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h4E;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h3D;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h47;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    CAPTURED
  } state_e;

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
  endfunction

  // Index of the highest set bit; only meaningful for one-hot inputs.
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational glyph decoder: segment pattern to hex nibble, flagging unknown patterns.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic [HEX_W-1:0] hex_c_o,
  output logic             err_c_o
);

  always_comb begin
    hex_c_o = '0;
    err_c_o = 1'b0;
    case (seg_i)
      GLYPH_0: hex_c_o = 4'h0;
      GLYPH_1: hex_c_o = 4'h1;
      GLYPH_2: hex_c_o = 4'h2;
      GLYPH_3: hex_c_o = 4'h3;
      GLYPH_4: hex_c_o = 4'h4;
      GLYPH_5: hex_c_o = 4'h5;
      GLYPH_6: hex_c_o = 4'h6;
      GLYPH_7: hex_c_o = 4'h7;
      GLYPH_8: hex_c_o = 4'h8;
      GLYPH_9: hex_c_o = 4'h9;
      GLYPH_A: hex_c_o = 4'hA;
      GLYPH_B: hex_c_o = 4'hB;
      GLYPH_C: hex_c_o = 4'hC;
      GLYPH_D: hex_c_o = 4'hD;
      GLYPH_E: hex_c_o = 4'hE;
      GLYPH_F: hex_c_o = 4'hF;
      default: err_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed 7-segment display scan and hands out 4-digit frames.
// Optional decimal-point capture is enabled by defining SEG7_DP_EN.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SEG_W-1:0]            seg,
  input  logic [NUM_DIGITS-1:0]       an,
`ifdef SEG7_DP_EN
  input  logic                        dp,
  output logic [NUM_DIGITS-1:0]       frame_dp,
`endif
  output logic [NUM_DIGITS*HEX_W-1:0] frame_data,
  output logic [NUM_DIGITS-1:0]       frame_err,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic                        overrun
);

`ifdef SEG7_DP_EN
  localparam int unsigned SAMPLE_W = NUM_DIGITS + SEG_W + 1;
`else
  localparam int unsigned SAMPLE_W = NUM_DIGITS + SEG_W;
`endif

  logic [SAMPLE_W-1:0] raw_sample;
  logic [SAMPLE_W-1:0] sync1_q, sync2_q, prev_q;
  state_e              state_q;
  logic [CNT_W-1:0]    count_q;

  logic [NUM_DIGITS-1:0][HEX_W-1:0] slot_q, slot_d;
  logic [NUM_DIGITS-1:0]            err_q, err_d;
  logic [NUM_DIGITS-1:0]            done_q, done_d;

  logic [NUM_DIGITS-1:0] samp_an;
  logic [SEG_W-1:0]      samp_seg;
  logic                  onehot_c, same_c, capture_c, frame_done_c;
  logic [IDX_W-1:0]      idx_c;
  logic [HEX_W-1:0]      dec_hex;
  logic                  dec_err;

`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  assign raw_sample = {dp, an, seg};
`else
  assign raw_sample = {an, seg};
`endif

  assign samp_an      = sync2_q[SEG_W +: NUM_DIGITS];
  assign samp_seg     = sync2_q[SEG_W-1:0];
  assign onehot_c     = is_onehot(samp_an);
  assign same_c       = (sync2_q == prev_q);
  assign idx_c        = onehot_idx(samp_an);
  assign capture_c    = (state_q == TRACK) && onehot_c && same_c &&
                        (count_q == CNT_W'(STABLE_CYCLES - 1));
  assign frame_done_c = (done_q == '1);

  seg7_pattern_decode u_decode (
    .seg_i   (samp_seg),
    .hex_c_o (dec_hex),
    .err_c_o (dec_err)
  );

  // Two-flop synchronizer for the asynchronous display lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_sample;
      sync2_q <= sync1_q;
    end
  end

  // Capture FSM: waits for a one-hot sample to stay unchanged for STABLE_CYCLES samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      prev_q  <= '0;
    end else begin
      prev_q <= sync2_q;
      case (state_q)
        IDLE: begin
          if (onehot_c) begin
            state_q <= TRACK;
            count_q <= CNT_W'(1);
          end
        end
        TRACK: begin
          if (!onehot_c) begin
            state_q <= IDLE;
            count_q <= '0;
          end else if (!same_c) begin
            count_q <= CNT_W'(1);
          end else if (capture_c) begin
            state_q <= CAPTURED;
            count_q <= CNT_W'(STABLE_CYCLES);
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        CAPTURED: begin
          if (!same_c) begin
            state_q <= onehot_c ? TRACK : IDLE;
            count_q <= onehot_c ? CNT_W'(1) : '0;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  // Working slots; a capture in the completion cycle is merged before the frame copy.
  always_comb begin
    slot_d = slot_q;
    err_d  = err_q;
    done_d = done_q;
`ifdef SEG7_DP_EN
    dp_d   = dp_q;
`endif
    if (capture_c) begin
      slot_d[idx_c] = dec_hex;
      err_d[idx_c]  = dec_err;
      done_d[idx_c] = 1'b1;
`ifdef SEG7_DP_EN
      dp_d[idx_c]   = sync2_q[SAMPLE_W-1];
`endif
    end
    if (frame_done_c) done_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= '0;
      err_q       <= '0;
      done_q      <= '0;
      frame_data  <= '0;
      frame_err   <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
`ifdef SEG7_DP_EN
      dp_q        <= '0;
      frame_dp    <= '0;
`endif
    end else begin
      slot_q <= slot_d;
      err_q  <= err_d;
      done_q <= done_d;
`ifdef SEG7_DP_EN
      dp_q   <= dp_d;
`endif
      if (frame_done_c) begin
        if (!frame_valid || frame_ready) begin
          frame_data  <= slot_d;
          frame_err   <= err_d;
          frame_valid <= 1'b1;
`ifdef SEG7_DP_EN
          frame_dp    <= dp_d;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomized and directed bench for seg7_scan_decoder against a run-length reference model.
module tb_seg7_scan_decoder;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = '0;
  logic [3:0]  an = '0;
  logic        frame_ready = 1'b0;
  logic [15:0] frame_data;
  logic [3:0]  frame_err;
  logic        frame_valid;
  logic        overrun;
`ifdef SEG7_DP_EN
  logic        dp = 1'b0;
  logic [3:0]  frame_dp;
`endif

  always #5 clk = ~clk;

  seg7_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
`ifdef SEG7_DP_EN
    .dp          (dp),
    .frame_dp    (frame_dp),
`endif
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          chk_en = 1'b0;
  bit          rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference: {err, hex} by table lookup.
  function automatic logic [4:0] decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) begin
      if (glyph[i] == s) return {1'b0, 4'(i)};
    end
    return 5'b1_0000;
  endfunction

  logic [10:0] m_s1 = '0, m_s2 = '0, m_prev = '0;
  int          m_run = 0;
  logic [15:0] m_slot = '0, m_fd = '0;
  logic [3:0]  m_err = '0, m_done = '0, m_fe = '0;
  logic        m_fv = 1'b0, m_ov = 1'b0;

  // A digit is captured on the sample where a one-hot run of identical samples reaches STABLE.
  task automatic model_step();
    logic [10:0] seen;
    logic [3:0]  a, nerr, ndone;
    logic [15:0] nslot;
    logic [4:0]  dec;
    int          id;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_run = 0;
      m_slot = '0; m_err = '0; m_done = '0;
      m_fd = '0; m_fe = '0; m_fv = 1'b0; m_ov = 1'b0;
      return;
    end
    seen  = m_s2;
    m_s2  = m_s1;
    m_s1  = {an, seg};
    a     = seen[10:7];
    nslot = m_slot;
    nerr  = m_err;
    ndone = m_done;
    if ($countones(a) == 1) begin
      m_run = (seen == m_prev) ? m_run + 1 : 1;
      if (m_run == STABLE) begin
        id = 0;
        for (int i = 0; i < 4; i++) if (a[i]) id = i;
        dec = decode(seen[6:0]);
        nslot[id*4 +: 4] = dec[3:0];
        nerr[id]  = dec[4];
        ndone[id] = 1'b1;
      end
    end else begin
      m_run = 0;
    end
    m_prev = seen;
    if (m_done == 4'hF) begin
      if (!m_fv || frame_ready) begin
        m_fd = nslot;
        m_fe = nerr;
        m_fv = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
      ndone = '0;
    end else if (m_fv && frame_ready) begin
      m_fv = 1'b0;
    end
    m_slot = nslot;
    m_err  = nerr;
    m_done = ndone;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("frame_valid", 32'(frame_valid), 32'(m_fv));
      chk("frame_data", 32'(frame_data), 32'(m_fd));
      chk("frame_err", 32'(frame_err), 32'(m_fe));
      chk("overrun", 32'(overrun), 32'(m_ov));
`ifdef SEG7_DP_EN
      chk("frame_dp", 32'(frame_dp), 32'h0);
`endif
    end
  end

  initial forever begin
    @(negedge clk);
    if (rand_rdy) frame_ready = 1'($urandom_range(0, 1));
  end

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int cyc);
    @(negedge clk);
    an  = a;
    seg = s;
    repeat (cyc) @(posedge clk);
  endtask

  task automatic scan(input logic [6:0] g0, input logic [6:0] g1,
                      input logic [6:0] g2, input logic [6:0] g3, input int hold);
    drive(4'b0001, g0, hold);
    drive(4'b0010, g1, hold);
    drive(4'b0100, g2, hold);
    drive(4'b1000, g3, hold);
  endtask

  task automatic accept();
    @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_data", 32'(frame_data), 32'h0);
    chk("rst_valid", 32'(frame_valid), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    rst = 1'b0;

    // Basic scan: digits 3,4,5,0.
    scan(7'h79, 7'h33, 7'h5B, 7'h7E, 8);
    drive(4'b0000, 7'h00, 4);
    @(negedge clk);
    chk("basic_data", 32'(frame_data), 32'h0543);
    chk("basic_err", 32'(frame_err), 32'h0);
    chk("basic_valid", 32'(frame_valid), 32'h1);
    accept();
    chk("basic_accept", 32'(frame_valid), 32'h0);

    // Digit 0 held one sample short of the threshold must not count.
    drive(4'b0001, glyph[0], STABLE - 1);
    drive(4'b0000, 7'h00, 3);
    drive(4'b0010, glyph[1], 8);
    drive(4'b0100, glyph[2], 8);
    drive(4'b1000, glyph[3], 8);
    drive(4'b0000, 7'h00, 6);
    @(negedge clk);
    chk("short_novalid", 32'(frame_valid), 32'h0);
    drive(4'b0001, glyph[0], 8);
    drive(4'b0000, 7'h00, 4);
    @(negedge clk);
    chk("short_data", 32'(frame_data), 32'h3210);
    accept();

    // Illegal glyph on digit 2.
    scan(7'h7E, 7'h30, 7'h01, 7'h79, 8);
    drive(4'b0000, 7'h00, 4);
    @(negedge clk);
    chk("illegal_err", 32'(frame_err), 32'h4);
    chk("illegal_data", 32'(frame_data), 32'h3010);
    accept();

    // Two frames with no acceptance: first is held, second dropped.
    scan(7'h77, 7'h1F, 7'h4E, 7'h3D, 8);
    drive(4'b0000, 7'h00, 4);
    scan(7'h4F, 7'h47, 7'h7F, 7'h7B, 8);
    drive(4'b0000, 7'h00, 4);
    @(negedge clk);
    chk("ovr_data", 32'(frame_data), 32'hDCBA);
    chk("ovr_flag", 32'(overrun), 32'h1);
    chk("ovr_valid", 32'(frame_valid), 32'h1);
    accept();
    chk("ovr_accept", 32'(frame_valid), 32'h0);

    // Reset while digit 3 is tracking.
    drive(4'b0001, glyph[1], 8);
    drive(4'b0010, glyph[2], 8);
    drive(4'b0100, glyph[3], 8);
    drive(4'b1000, glyph[4], 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_data", 32'(frame_data), 32'h0);
    chk("mid_rst_ovr", 32'(overrun), 32'h0);
    chk("mid_rst_valid", 32'(frame_valid), 32'h0);
    scan(7'h5F, 7'h70, 7'h7F, 7'h7B, 8);
    drive(4'b0000, 7'h00, 4);
    @(negedge clk);
    chk("post_rst_data", 32'(frame_data), 32'h9876);
    accept();

    // Two digit enables at once never capture.
    drive(4'b0011, glyph[8], 10);
    drive(4'b0000, 7'h00, 4);
    @(negedge clk);
    chk("multi_an_valid", 32'(frame_valid), 32'h0);

    // Randomized scans with jittery hold times, glitches and random back-pressure.
    rand_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int d = 0; d < 4; d++) begin
        logic [3:0] a;
        logic [6:0] s;
        a = 4'(1 << d);
        if ($urandom_range(0, 9) == 0) a = 4'($urandom);
        s = glyph[$urandom_range(0, 15)];
        if ($urandom_range(0, 6) == 0) s = 7'($urandom);
        drive(a, s, int'($urandom_range(1, 10)));
      end
      if ($urandom_range(0, 3) == 0) drive(4'b0000, 7'h00, int'($urandom_range(1, 4)));
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    rand_rdy = 1'b0;
    drive(4'b0000, 7'h00, 6);
    @(negedge clk);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, is the number of consecutive identical synchronized samples required before a digit is captured (legal range 2..255).
REQ-002 Ports: clk  in  1  single clock; all logic on rising edge.
REQ-003 Ports: rst  in  1  synchronous, active-high reset.
REQ-004 Ports: seg  in  7  segment lines, active-high, seg[6]=a ... seg[0]=g; asynchronous to clk.
REQ-005 Ports: an  in  4  digit enables, active-high, an[i] selects digit i; asynchronous to clk.
REQ-006 Ports: frame_data  out  16  captured hex digits, digit i at [4i+3:4i].
REQ-007 Ports: frame_err  out  4  bit i set when digit i's pattern was not a legal hex glyph.
REQ-008 Ports: frame_valid  out  1  frame_data/frame_err hold a complete, unaccepted frame.
REQ-009 Ports: frame_ready  in  1  consumer accepts the frame when high with frame_valid.
REQ-010 Ports: overrun  out  1  sticky flag: a completed frame was dropped.

Function
REQ-011 seg and an SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The capture FSM SHALL have exactly three states: IDLE, TRACK and CAPTURED.
REQ-013 IDLE: if the synchronized an is not one-hot, the FSM SHALL stay in IDLE; if it is one-hot, the FSM SHALL go to TRACK with count=1.
REQ-014 TRACK: if the {an,seg} sample equals the previous sample, count SHALL increment; if it differs and an is one-hot, count SHALL restart at 1; if an is not one-hot, the FSM SHALL go to IDLE.
REQ-015 TRACK: when count reaches STABLE_CYCLES, the FSM SHALL write the decoded digit into working slot i, set done[i], and go to CAPTURED.
REQ-016 CAPTURED: the FSM SHALL hold while the sample is unchanged; on any change it SHALL go to TRACK (one-hot an) or IDLE (otherwise); a static display SHALL NOT be recaptured.
REQ-017 Latency: the working slot SHALL update at edge STABLE_CYCLES+2 after the inputs settle.
REQ-018 Glyph decoding SHALL use these codes: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47; any other code SHALL store value 0 with err[i]=1.
REQ-019 A recapture of digit i before the frame completes SHALL overwrite slot i and err[i].
REQ-020 When done==4'hF, if (!frame_valid || frame_ready), the working slots SHALL copy to frame_data/frame_err and frame_valid SHALL be 1 next cycle.
REQ-021 Otherwise (done==4'hF with the output slot held), the completed frame SHALL be discarded and overrun SHALL be set.
REQ-022 In both REQ-020 and REQ-021 cases, done SHALL clear.
REQ-023 Acceptance (frame_valid && frame_ready) without a new frame SHALL clear frame_valid next cycle.
REQ-024 frame_data SHALL remain stable while frame_valid && !frame_ready.
REQ-025 A capture and a frame completion in the same cycle SHALL include the newly captured digit in the completed frame.

Reset
REQ-026 With rst high at a clock edge: FSM=IDLE, count=0, synchronizers=0, done=0, working slots=0.
REQ-027 With rst high at a clock edge: frame_data=0, frame_err=0, frame_valid=0, overrun=0.
REQ-028 Reset mid-capture or mid-handshake SHALL discard all partial and pending data.
REQ-029 overrun SHALL clear only on reset.

Configuration
REQ-030 With SEG7_DP_EN defined: input dp (1 bit) and output frame_dp (4 bits) SHALL exist; dp SHALL be synchronized, included in the stability compare, and captured per digit like err.
REQ-031 Without SEG7_DP_EN: the dp and frame_dp ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package seg7_pkg SHALL hold the glyph constants, the FSM state enum, and the digit-count constant 4.
REQ-033 Sub-module seg7_pattern_decode SHALL perform the combinational mapping seg[6:0] -> {err, hex[3:0]}.

Verification
REQ-034 Scan digits 0..3 with glyphs 79,33,5B,7E, each held 8 cycles -> frame_data=16'h0543, frame_err=0, one frame_valid assertion.
REQ-035 Glyph held only STABLE_CYCLES-1 samples -> no capture, done unchanged.
REQ-036 Digit 2 driven with seg=7'h01 -> frame_err=4'b0100 and that nibble=0.
REQ-037 frame_ready=0 while two full frames complete -> first frame is held unchanged, overrun=1; after frame_ready=1, frame_valid=0 next cycle.
REQ-038 Assert rst during digit 3 TRACK after digits 0..2 are captured -> all outputs 0; a following full scan yields a correct frame.
REQ-039 an=4'b0011 for 10 cycles -> FSM stays IDLE, no capture.
